fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the control decoder.
- Owns the program counter and drives the synchronous instruction memory address.
- Presents each 9-bit machine code with a valid qualifier.
- Resolves taken branches through a loadable 64-entry jump-target table, and halts on the decoder's Done.

---
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_unit.sv | 62 ++++++
 tb/tb_fetch_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: fetch stage bus covering control, instruction memory, decoder feedback, jump table and status
interface fetch_if #(parameter int PC_W = 10, parameter int CNT_W = 16);
  logic             Start;
  logic [PC_W-1:0]  ImemAddr;
  logic [8:0]       ImemData;
  logic [8:0]       MachCode;
  logic             MachValid;
  logic             Jen;
  logic             Cond;
  logic [7:0]       Jptr;
  logic             Done;
  logic             LutWe;
  logic [5:0]       LutAddr;
  logic [PC_W-1:0]  LutData;
  logic             Busy;
  logic             Halted;
  logic [CNT_W-1:0] CycleCount;
  modport master (
    input  Start, ImemData, Jen, Cond, Jptr, Done, LutWe, LutAddr, LutData,
    output ImemAddr, MachCode, MachValid, Busy, Halted, CycleCount
  );
  modport slave (
    output Start, ImemData, Jen, Cond, Jptr, Done, LutWe, LutAddr, LutData,
    input  ImemAddr, MachCode, MachValid, Busy, Halted, CycleCount
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner with jump-table branches, one-bubble squash on taken branch, halt on Done
module fetch_unit #(
  parameter int PC_W       = 10,
  parameter int PROG_START = 0,
  parameter int CNT_W      = 16
) (
  input logic      Clk,
  input logic      Reset,
  fetch_if.master  bus
);
  typedef enum logic [1:0] {IDLE, PRIME, RUN, HALT} state_t;
  state_t state, state_n;
  logic [PC_W-1:0] addr;
  logic [CNT_W-1:0] cnt;
  logic [PC_W-1:0] lut [64];
  logic squash, valid, done, taken, start_ok, active;
  logic unused;
  assign unused = ^bus.Jptr[7:6];
  always_comb begin
    state_n = state;
    valid = state == RUN && !squash;
    done = valid && bus.Done;
    // Done outranks a simultaneous branch
    taken = valid && bus.Jen && bus.Cond && !bus.Done;
    start_ok = (state == IDLE || state == HALT) && bus.Start;
    active = state == PRIME || state == RUN;
    case (state)
      IDLE:    state_n = bus.Start ? PRIME : IDLE;
      PRIME:   state_n = RUN;
      RUN:     state_n = done ? HALT : RUN;
      default: state_n = bus.Start ? PRIME : HALT;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      addr <= '0;
      cnt <= '0;
      squash <= 1'b0;
    end else begin
      state <= state_n;
      squash <= taken;
      if (start_ok) begin
        addr <= PC_W'(PROG_START);
        cnt <= '0;
      end else if (active) begin
        addr <= taken ? lut[bus.Jptr[5:0]] : done ? addr : addr + 1'b1;
        cnt <= &cnt ? cnt : cnt + 1'b1;
      end
    end
  end
  // Table survives reset; a same-cycle read sees the pre-write entry
  always_ff @(posedge Clk) begin
    if (bus.LutWe) lut[bus.LutAddr] <= bus.LutData;
  end
  assign bus.ImemAddr = addr;
  assign bus.MachCode = bus.ImemData;
  assign bus.MachValid = valid;
  assign bus.Busy = active;
  assign bus.Halted = state == HALT;
  assign bus.CycleCount = cnt;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch sequencing, branches, halt, jump table and reset
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [8:0] mem [1024];
  fetch_if #(.PC_W(10), .CNT_W(16)) bus ();
  fetch_unit #(.PC_W(10), .PROG_START(0), .CNT_W(16)) dut (.Clk(clk), .Reset(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.ImemData <= mem[bus.ImemAddr];
  function automatic logic [8:0] code_of(input int a);
    return 9'(a * 37 + 11);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    bus.Start = 0; bus.Jen = 0; bus.Cond = 0; bus.Jptr = 0; bus.Done = 0;
    bus.LutWe = 0; bus.LutAddr = 0; bus.LutData = 0;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = code_of(i);
    bus.ImemData = 0;
    clr();
    step(); step();
    rst = 0;
    chk("rst_addr", 32'(bus.ImemAddr), 0);
    chk("rst_valid", 32'(bus.MachValid), 0);
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_halted", 32'(bus.Halted), 0);
    chk("rst_cnt", 32'(bus.CycleCount), 0);
    bus.LutWe = 1; bus.LutAddr = 5; bus.LutData = 10'h040; step();
    bus.LutAddr = 2; bus.LutData = 10'h123; step();
    bus.LutWe = 0;
    bus.Start = 1; step(); bus.Start = 0;
    chk("prime_addr", 32'(bus.ImemAddr), 0);
    chk("prime_valid", 32'(bus.MachValid), 0);
    chk("prime_busy", 32'(bus.Busy), 1);
    chk("prime_cnt", 32'(bus.CycleCount), 0);
    for (int c = 2; c <= 5; c++) begin
      step();
      chk("seq_addr", 32'(bus.ImemAddr), 32'(c - 1));
      chk("seq_valid", 32'(bus.MachValid), 1);
      chk("seq_code", 32'(bus.MachCode), 32'(code_of(c - 2)));
    end
    chk("seq_cnt", 32'(bus.CycleCount), 4);
    bus.Jen = 1; bus.Cond = 1; bus.Jptr = 8'h05; step(); clr();
    chk("br_addr", 32'(bus.ImemAddr), 32'h040);
    chk("br_squash", 32'(bus.MachValid), 0);
    step();
    chk("br_tgt_valid", 32'(bus.MachValid), 1);
    chk("br_tgt_code", 32'(bus.MachCode), 32'(code_of(32'h040)));
    chk("br_tgt_addr", 32'(bus.ImemAddr), 32'h041);
    step();
    chk("pre_done_addr", 32'(bus.ImemAddr), 32'h042);
    chk("pre_done_cnt", 32'(bus.CycleCount), 7);
    bus.Done = 1; bus.Jen = 1; bus.Cond = 1; bus.Jptr = 8'h05; step(); clr();
    chk("halt_halted", 32'(bus.Halted), 1);
    chk("halt_valid", 32'(bus.MachValid), 0);
    chk("halt_busy", 32'(bus.Busy), 0);
    chk("halt_addr", 32'(bus.ImemAddr), 32'h042);
    chk("halt_cnt", 32'(bus.CycleCount), 8);
    step(); step();
    chk("halt_addr_hold", 32'(bus.ImemAddr), 32'h042);
    chk("halt_cnt_hold", 32'(bus.CycleCount), 8);
    bus.Start = 1; step(); bus.Start = 0;
    chk("restart_addr", 32'(bus.ImemAddr), 0);
    chk("restart_cnt", 32'(bus.CycleCount), 0);
    chk("restart_halted", 32'(bus.Halted), 0);
    chk("restart_busy", 32'(bus.Busy), 1);
    repeat (4) step();
    chk("r2_code3", 32'(bus.MachCode), 32'(code_of(3)));
    bus.Jen = 1; bus.Cond = 0; bus.Jptr = 8'h05; step(); clr();
    chk("untaken_valid", 32'(bus.MachValid), 1);
    chk("untaken_code", 32'(bus.MachCode), 32'(code_of(4)));
    chk("untaken_addr", 32'(bus.ImemAddr), 5);
    bus.Start = 1; step(); bus.Start = 0;
    chk("run_start_ign", 32'(bus.ImemAddr), 6);
    chk("run_start_code", 32'(bus.MachCode), 32'(code_of(5)));
    bus.LutWe = 1; bus.LutAddr = 2; bus.LutData = 10'h3FF;
    bus.Jen = 1; bus.Cond = 1; bus.Jptr = 8'h82; step(); clr();
    chk("lut_old_addr", 32'(bus.ImemAddr), 32'h123);
    chk("lut_old_squash", 32'(bus.MachValid), 0);
    step();
    chk("lut_old_code", 32'(bus.MachCode), 32'(code_of(32'h123)));
    bus.Jen = 1; bus.Cond = 1; bus.Jptr = 8'h82; step(); clr();
    chk("lut_new_addr", 32'(bus.ImemAddr), 32'h3FF);
    step();
    chk("wrap_addr", 32'(bus.ImemAddr), 0);
    chk("wrap_code", 32'(bus.MachCode), 32'(code_of(32'h3FF)));
    chk("wrap_valid", 32'(bus.MachValid), 1);
    step();
    chk("wrap_next", 32'(bus.ImemAddr), 1);
    repeat (15) step();
    chk("mid_addr", 32'(bus.ImemAddr), 32'h010);
    rst = 1; step(); rst = 0;
    chk("mid_rst_addr", 32'(bus.ImemAddr), 0);
    chk("mid_rst_valid", 32'(bus.MachValid), 0);
    chk("mid_rst_busy", 32'(bus.Busy), 0);
    chk("mid_rst_halted", 32'(bus.Halted), 0);
    chk("mid_rst_cnt", 32'(bus.CycleCount), 0);
    bus.Start = 1; step(); clr();
    bus.Jen = 1; bus.Cond = 1; bus.Done = 1; bus.Jptr = 8'h05; step(); clr();
    chk("inv_ign_addr", 32'(bus.ImemAddr), 1);
    chk("inv_ign_valid", 32'(bus.MachValid), 1);
    chk("inv_ign_halted", 32'(bus.Halted), 0);
    bus.Jen = 1; bus.Cond = 1; bus.Jptr = 8'h02; step(); clr();
    chk("lut_retained", 32'(bus.ImemAddr), 32'h3FF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
